qpu_exu_ir_rx: RTL and testbench
================================

# qpu_exu_ir_rx

EXU-side receiver for the IFU instruction-issue handshake, plus the initiator of the IFU pipeline-flush request. Accepts instructions from `QPU_ifu_top` on the `ifu_o_*` valid/ready interface and buffers them in a small in-order queue for the dispatch stage. On a branch or redirect resolution it kills all buffered instructions, then drives `pipe_flush_req` with the target operands until the IFU acknowledges.

## Interface
- `IBUF_DEPTH`, 2: queue entries; power of two, ≥2.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ifu_o_valid` in 1: IFU instruction valid.
- `ifu_o_ready` out 1: receiver can accept.
- `ifu_o_ir` in `QPU_INSTR_SIZE`: instruction.
- `ifu_o_pc` in `QPU_PC_SIZE`: PC.
- `ifu_o_pc_vld` in 1: PC valid.
- `ifu_o_rs1idx`, `ifu_o_rs2idx` in `QPU_RFIDX_REAL_WIDTH` each: source register indices.
- `ifu_o_prdt_taken` in 1: predicted taken.
- `disp_i_valid` out 1: entry presented to dispatch.
- `disp_i_ready` in 1: dispatch accepts.
- `disp_i_ir`, `disp_i_pc`, `disp_i_pc_vld`, `disp_i_rs1idx`, `disp_i_rs2idx`, `disp_i_prdt_taken` out: head entry fields, same widths as the `ifu_o_*` fields.
- `redir_req` in 1: redirect request from branch resolution.
- `redir_op1`, `redir_op2` in `QPU_PC_SIZE`: target operands.
- `redir_ready` out 1: redirect can be accepted.
- `pipe_flush_req` out 1: flush request to IFU.
- `pipe_flush_add_op1`, `pipe_flush_add_op2` out `QPU_PC_SIZE`: latched target operands.
- `pipe_flush_ack` in 1: IFU flush acknowledge.
- `exu_rx_active` out 1: queue non-empty or flush pending.

## Operation
- State machine with two states:
  - IDLE (reset): normal operation.
  - FLUSH: `pipe_flush_req`=1.
- Queue: circular buffer with read pointer, write pointer and count (`$clog2(IBUF_DEPTH)+1` bits); pointers wrap modulo `IBUF_DEPTH`.
- `ifu_o_ready` = (count<IBUF_DEPTH) & IDLE & ~`redir_req`.
  - Push occurs when `ifu_o_valid` & `ifu_o_ready`.
- `disp_i_valid` = (count>0) & IDLE & ~`redir_req`.
  - Pop occurs when `disp_i_valid` & `disp_i_ready`.
  - Push and pop in the same cycle leave count unchanged.
  - When full, `ifu_o_ready`=0, so a simultaneous pop+push at full cannot happen.
- `redir_ready` = IDLE. Redirect is accepted when `redir_req` & `redir_ready`. At that edge:
  - count and both pointers are cleared (all entries killed);
  - `redir_op1` and `redir_op2` are latched into `pipe_flush_add_op1/2`;
  - state goes to FLUSH.
- A `redir_req` that arrives while in FLUSH is ignored.
- In FLUSH:
  - `ifu_o_ready`=0 and `disp_i_valid`=0;
  - when `pipe_flush_ack`=1, state returns to IDLE at the next edge;
  - the flush operands hold stable until then.
- Reset values (asynchronous):
  - state IDLE; count and pointers 0; `pipe_flush_req` 0; flush operands 0;
  - therefore `ifu_o_ready`=1 after reset (if `redir_req`=0), `disp_i_valid`=0, `exu_rx_active`=0.
  - Reset asserted mid-flush drops the request immediately.
- Queue payload registers need no reset; `disp_i_*` fields are don't-care while `disp_i_valid`=0.

## Timing
- Push-to-dispatch latency is 1 cycle: an instruction accepted at edge N is on `disp_i_*` with `disp_i_valid`=1 after edge N.
- Sustained throughput is 1 instruction/cycle once the queue is non-empty and dispatch is ready.
- `pipe_flush_req` rises 1 cycle after the redirect is accepted.
  - If `pipe_flush_ack` is already 1 in that first cycle, it falls after exactly one cycle.
  - Ack while `pipe_flush_req`=0 is ignored.
- The first new `ifu_o_ready` after a flush is in the cycle following the ack edge.

## Configuration
- `QPU_EXU_IR_RX_BYPASS_EN` defined: when count=0 and IDLE, `disp_i_valid`=`ifu_o_valid` & ~`redir_req`, and `disp_i_*` are driven combinationally from `ifu_o_*`.
  - If `disp_i_ready`=1 in that cycle, the instruction is handed off with zero latency and not written to the queue.
  - Otherwise it is pushed normally.
- Undefined: no bypass; all instructions pass through the queue with the 1-cycle latency above.

## Test plan
- Reset then stream: `ifu_o_valid`=1 and `disp_i_ready`=1 with PCs 0x0, 0x4, 0x8 on consecutive cycles -> `disp_i_pc` shows 0x0, 0x4, 0x8 in order, one cycle later (same cycle with bypass).
- Backpressure: `disp_i_ready`=0 with 3 valid pushes and `IBUF_DEPTH`=2 -> `ifu_o_ready` drops after the 2nd push; raising `disp_i_ready` delivers both entries in order, then the 3rd.
- Redirect with 2 entries queued: `redir_req`=1, op1=0x100, op2=0x20 -> queue empty next cycle, `pipe_flush_req`=1 with add_op1=0x100 and add_op2=0x20, `ifu_o_ready`=0 until ack.
- Ack timing: ack asserted 3 cycles after `pipe_flush_req` rises -> req falls next edge and `ifu_o_ready` returns to 1; a second `redir_req` during FLUSH leaves the operands unchanged.
- Simultaneous events: `redir_req` in the same cycle as `ifu_o_valid` and a pending dispatch -> no push, no pop, and the subsequent queue count is 0.
- Async reset asserted in FLUSH mid-cycle -> `pipe_flush_req`=0 immediately, count 0, `ifu_o_ready`=1 after release.

Source files
------------

// File: rtl/qpu_exu_ir_rx.sv
// EXU-side receiver for IFU instruction issue: in-order queue to dispatch plus IFU flush initiator.
// Optional zero-latency bypass when the queue is empty: define QPU_EXU_IR_RX_BYPASS_EN.
module qpu_exu_ir_rx #(
  parameter int IBUF_DEPTH           = 2,
  parameter int QPU_INSTR_SIZE       = 32,
  parameter int QPU_PC_SIZE          = 32,
  parameter int QPU_RFIDX_REAL_WIDTH = 5
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            ifu_o_valid,
  output logic                            ifu_o_ready,
  input  logic [QPU_INSTR_SIZE-1:0]       ifu_o_ir,
  input  logic [QPU_PC_SIZE-1:0]          ifu_o_pc,
  input  logic                            ifu_o_pc_vld,
  input  logic [QPU_RFIDX_REAL_WIDTH-1:0] ifu_o_rs1idx,
  input  logic [QPU_RFIDX_REAL_WIDTH-1:0] ifu_o_rs2idx,
  input  logic                            ifu_o_prdt_taken,
  output logic                            disp_i_valid,
  input  logic                            disp_i_ready,
  output logic [QPU_INSTR_SIZE-1:0]       disp_i_ir,
  output logic [QPU_PC_SIZE-1:0]          disp_i_pc,
  output logic                            disp_i_pc_vld,
  output logic [QPU_RFIDX_REAL_WIDTH-1:0] disp_i_rs1idx,
  output logic [QPU_RFIDX_REAL_WIDTH-1:0] disp_i_rs2idx,
  output logic                            disp_i_prdt_taken,
  input  logic                            redir_req,
  input  logic [QPU_PC_SIZE-1:0]          redir_op1,
  input  logic [QPU_PC_SIZE-1:0]          redir_op2,
  output logic                            redir_ready,
  output logic                            pipe_flush_req,
  output logic [QPU_PC_SIZE-1:0]          pipe_flush_add_op1,
  output logic [QPU_PC_SIZE-1:0]          pipe_flush_add_op2,
  input  logic                            pipe_flush_ack,
  output logic                            exu_rx_active
);

  localparam int PTR_W = $clog2(IBUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(IBUF_DEPTH);

  typedef enum logic {IDLE, FLUSH} state_e;

  typedef struct packed {
    logic [QPU_INSTR_SIZE-1:0]       ir;
    logic [QPU_PC_SIZE-1:0]          pc;
    logic                            pc_vld;
    logic [QPU_RFIDX_REAL_WIDTH-1:0] rs1idx;
    logic [QPU_RFIDX_REAL_WIDTH-1:0] rs2idx;
    logic                            prdt_taken;
  } entry_t;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [QPU_PC_SIZE-1:0] op1_q, op1_d;
  logic [QPU_PC_SIZE-1:0] op2_q, op2_d;
  entry_t                 mem_q [IBUF_DEPTH];

  entry_t ifu_entry;
  entry_t disp_entry;
  logic   idle;
  logic   q_valid;
  logic   byp_take;
  logic   push;
  logic   pop;
  logic   redir_acc;

  assign ifu_entry = '{ir: ifu_o_ir, pc: ifu_o_pc, pc_vld: ifu_o_pc_vld,
                       rs1idx: ifu_o_rs1idx, rs2idx: ifu_o_rs2idx,
                       prdt_taken: ifu_o_prdt_taken};

  assign idle        = (state_q == IDLE);
  assign ifu_o_ready = (cnt_q < DEPTH_C) && idle && !redir_req;
  assign q_valid     = (cnt_q != '0) && idle && !redir_req;
  assign redir_ready = idle;
  assign redir_acc   = redir_req && idle;

`ifdef QPU_EXU_IR_RX_BYPASS_EN
  logic byp_sel;
  // Empty queue: the IFU beat goes straight to dispatch and is only queued if not taken.
  assign byp_sel      = (cnt_q == '0) && idle;
  assign disp_i_valid = byp_sel ? (ifu_o_valid && !redir_req) : q_valid;
  assign disp_entry   = byp_sel ? ifu_entry : mem_q[rd_ptr_q];
  assign byp_take     = byp_sel && ifu_o_valid && !redir_req && disp_i_ready;
`else
  assign disp_i_valid = q_valid;
  assign disp_entry   = mem_q[rd_ptr_q];
  assign byp_take     = 1'b0;
`endif

  assign push = ifu_o_valid && ifu_o_ready && !byp_take;
  assign pop  = q_valid && disp_i_ready;

  assign disp_i_ir         = disp_entry.ir;
  assign disp_i_pc         = disp_entry.pc;
  assign disp_i_pc_vld     = disp_entry.pc_vld;
  assign disp_i_rs1idx     = disp_entry.rs1idx;
  assign disp_i_rs2idx     = disp_entry.rs2idx;
  assign disp_i_prdt_taken = disp_entry.prdt_taken;

  assign pipe_flush_req     = (state_q == FLUSH);
  assign pipe_flush_add_op1 = op1_q;
  assign pipe_flush_add_op2 = op2_q;
  assign exu_rx_active      = (cnt_q != '0) || !idle;

  // NOTE: every variable gets a default before any branch, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    op1_d    = op1_q;
    op2_d    = op2_q;

    case (state_q)
      IDLE: begin
        if (redir_acc) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (pipe_flush_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (redir_acc) begin
      cnt_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      op1_d    = redir_op1;
      op2_d    = redir_op2;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
    end
  end

  // NOTE: payload storage is deliberately unreset; cnt_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= ifu_entry;
    end
  end

endmodule

// File: tb/tb_qpu_exu_ir_rx.sv
// Scoreboard bench for qpu_exu_ir_rx: directed stimulus queues expected PCs, a monitor checks dispatch.
module tb_qpu_exu_ir_rx;

`ifdef QPU_EXU_IR_RX_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ifu_o_valid = 1'b0;
  logic        ifu_o_ready;
  logic [31:0] ifu_o_ir = '0;
  logic [31:0] ifu_o_pc = '0;
  logic        ifu_o_pc_vld = 1'b0;
  logic [4:0]  ifu_o_rs1idx = '0;
  logic [4:0]  ifu_o_rs2idx = '0;
  logic        ifu_o_prdt_taken = 1'b0;
  logic        disp_i_valid;
  logic        disp_i_ready = 1'b0;
  logic [31:0] disp_i_ir;
  logic [31:0] disp_i_pc;
  logic        disp_i_pc_vld;
  logic [4:0]  disp_i_rs1idx;
  logic [4:0]  disp_i_rs2idx;
  logic        disp_i_prdt_taken;
  logic        redir_req = 1'b0;
  logic [31:0] redir_op1 = '0;
  logic [31:0] redir_op2 = '0;
  logic        redir_ready;
  logic        pipe_flush_req;
  logic [31:0] pipe_flush_add_op1;
  logic [31:0] pipe_flush_add_op2;
  logic        pipe_flush_ack = 1'b0;
  logic        exu_rx_active;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  qpu_exu_ir_rx #(.IBUF_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_o_valid(ifu_o_valid), .ifu_o_ready(ifu_o_ready), .ifu_o_ir(ifu_o_ir),
    .ifu_o_pc(ifu_o_pc), .ifu_o_pc_vld(ifu_o_pc_vld), .ifu_o_rs1idx(ifu_o_rs1idx),
    .ifu_o_rs2idx(ifu_o_rs2idx), .ifu_o_prdt_taken(ifu_o_prdt_taken),
    .disp_i_valid(disp_i_valid), .disp_i_ready(disp_i_ready), .disp_i_ir(disp_i_ir),
    .disp_i_pc(disp_i_pc), .disp_i_pc_vld(disp_i_pc_vld), .disp_i_rs1idx(disp_i_rs1idx),
    .disp_i_rs2idx(disp_i_rs2idx), .disp_i_prdt_taken(disp_i_prdt_taken),
    .redir_req(redir_req), .redir_op1(redir_op1), .redir_op2(redir_op2),
    .redir_ready(redir_ready), .pipe_flush_req(pipe_flush_req),
    .pipe_flush_add_op1(pipe_flush_add_op1), .pipe_flush_add_op2(pipe_flush_add_op2),
    .pipe_flush_ack(pipe_flush_ack), .exu_rx_active(exu_rx_active)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction payload fields are derived from the PC so each beat is distinguishable.
  function automatic logic [31:0] ir_of(input logic [31:0] pc);
    return 32'h0000_0013 ^ (pc << 8);
  endfunction

  task automatic drive(input logic [31:0] pc);
    ifu_o_valid      = 1'b1;
    ifu_o_pc         = pc;
    ifu_o_ir         = ir_of(pc);
    ifu_o_pc_vld     = 1'b1;
    ifu_o_rs1idx     = pc[6:2];
    ifu_o_rs2idx     = ~pc[6:2];
    ifu_o_prdt_taken = pc[2];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds the beat until the receiver accepts it; the expected PC is queued up front.
  task automatic send(input logic [31:0] pc);
    int n;
    drive(pc);
    exp_q.push_back(pc);
    n = 0;
    @(negedge clk);
    while (!ifu_o_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("send_ready", {63'd0, ifu_o_ready}, 64'd1);
    step();
    ifu_o_valid = 1'b0;
  endtask

  // Monitor: a dispatch handshake completes at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && disp_i_valid && disp_i_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_disp: got pc %0h expected no dispatch (t=%0t)", disp_i_pc, $time);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("disp_pc",     {32'd0, disp_i_pc}, {32'd0, e});
        check("disp_ir",     {32'd0, disp_i_ir}, {32'd0, ir_of(e)});
        check("disp_rs1",    {59'd0, disp_i_rs1idx}, {59'd0, e[6:2]});
        check("disp_rs2",    {59'd0, disp_i_rs2idx}, {59'd0, ~e[6:2]});
        check("disp_prdt",   {63'd0, disp_i_prdt_taken}, {63'd0, e[2]});
        check("disp_pc_vld", {63'd0, disp_i_pc_vld}, 64'd1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_ifu_ready", {63'd0, ifu_o_ready}, 64'd1);
    check("rst_disp_valid", {63'd0, disp_i_valid}, 64'd0);
    check("rst_active", {63'd0, exu_rx_active}, 64'd0);
    check("rst_flush_req", {63'd0, pipe_flush_req}, 64'd0);
    check("rst_op1", {32'd0, pipe_flush_add_op1}, 64'd0);
    check("rst_redir_ready", {63'd0, redir_ready}, 64'd1);

    // Streaming PCs 0x0, 0x4, 0x8 with dispatch always ready.
    step();
    disp_i_ready = 1'b1;
    drive(32'h0); exp_q.push_back(32'h0);
    @(negedge clk);
    check("stream_first_valid", {63'd0, disp_i_valid}, {63'd0, BYP});
    check("stream_rdy0", {63'd0, ifu_o_ready}, 64'd1);
    step();
    drive(32'h4); exp_q.push_back(32'h4);
    @(negedge clk);
    check("stream_lat_valid", {63'd0, disp_i_valid}, 64'd1);
    check("stream_rdy1", {63'd0, ifu_o_ready}, 64'd1);
    step();
    drive(32'h8); exp_q.push_back(32'h8);
    @(negedge clk);
    check("stream_rdy2", {63'd0, ifu_o_ready}, 64'd1);
    step();
    ifu_o_valid = 1'b0;
    repeat (3) step();
    check("stream_drain", 64'(exp_q.size()), 64'd0);

    // Backpressure: two entries fill the queue, the third waits.
    disp_i_ready = 1'b0;
    send(32'h10);
    send(32'h14);
    @(negedge clk);
    check("full_ifu_ready", {63'd0, ifu_o_ready}, 64'd0);
    check("full_active", {63'd0, exu_rx_active}, 64'd1);
    check("full_disp_valid", {63'd0, disp_i_valid}, 64'd1);
    step();
    disp_i_ready = 1'b1;
    send(32'h18);
    repeat (3) step();
    check("bp_drain", 64'(exp_q.size()), 64'd0);

    // Redirect with two entries queued, late ack, ignored second redirect.
    disp_i_ready = 1'b0;
    send(32'h20);
    send(32'h24);
    redir_req = 1'b1; redir_op1 = 32'h100; redir_op2 = 32'h20;
    @(negedge clk);
    check("redir_ready_idle", {63'd0, redir_ready}, 64'd1);
    check("redir_blocks_push", {63'd0, ifu_o_ready}, 64'd0);
    check("redir_blocks_disp", {63'd0, disp_i_valid}, 64'd0);
    step();
    redir_req = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("flush_req_up", {63'd0, pipe_flush_req}, 64'd1);
    check("flush_op1", {32'd0, pipe_flush_add_op1}, 64'h100);
    check("flush_op2", {32'd0, pipe_flush_add_op2}, 64'h20);
    check("flush_ifu_ready", {63'd0, ifu_o_ready}, 64'd0);
    check("flush_disp_valid", {63'd0, disp_i_valid}, 64'd0);
    check("flush_redir_ready", {63'd0, redir_ready}, 64'd0);
    check("flush_active", {63'd0, exu_rx_active}, 64'd1);
    step();
    redir_req = 1'b1; redir_op1 = 32'h200; redir_op2 = 32'h40;
    @(negedge clk);
    step();
    redir_req = 1'b0;
    @(negedge clk);
    check("flush_hold_op1", {32'd0, pipe_flush_add_op1}, 64'h100);
    check("flush_hold_op2", {32'd0, pipe_flush_add_op2}, 64'h20);
    step();
    pipe_flush_ack = 1'b1;
    @(negedge clk);
    check("flush_req_before_ack_edge", {63'd0, pipe_flush_req}, 64'd1);
    check("ifu_ready_before_ack_edge", {63'd0, ifu_o_ready}, 64'd0);
    step();
    pipe_flush_ack = 1'b0;
    disp_i_ready = 1'b1;
    @(negedge clk);
    check("flush_req_down", {63'd0, pipe_flush_req}, 64'd0);
    check("post_flush_ready", {63'd0, ifu_o_ready}, 64'd1);
    check("post_flush_empty", {63'd0, exu_rx_active}, 64'd0);
    check("post_flush_disp", {63'd0, disp_i_valid}, 64'd0);

    // Ack without a pending flush does nothing.
    step();
    pipe_flush_ack = 1'b1;
    step();
    pipe_flush_ack = 1'b0;
    @(negedge clk);
    check("stray_ack_req", {63'd0, pipe_flush_req}, 64'd0);
    check("stray_ack_redir_ready", {63'd0, redir_ready}, 64'd1);

    // Redirect together with a push and a pending dispatch; ack in the first flush cycle.
    step();
    disp_i_ready = 1'b0;
    send(32'h30);
    disp_i_ready = 1'b1;
    drive(32'h34);
    redir_req = 1'b1; redir_op1 = 32'h300; redir_op2 = 32'h4;
    @(negedge clk);
    check("simul_no_push", {63'd0, ifu_o_ready}, 64'd0);
    check("simul_no_pop", {63'd0, disp_i_valid}, 64'd0);
    step();
    exp_q.delete();
    ifu_o_valid = 1'b0;
    redir_req = 1'b0;
    pipe_flush_ack = 1'b1;
    @(negedge clk);
    check("simul_flush_req", {63'd0, pipe_flush_req}, 64'd1);
    check("simul_op1", {32'd0, pipe_flush_add_op1}, 64'h300);
    step();
    pipe_flush_ack = 1'b0;
    @(negedge clk);
    check("ack_first_cycle_req", {63'd0, pipe_flush_req}, 64'd0);
    check("simul_count_zero", {63'd0, exu_rx_active}, 64'd0);
    check("simul_disp_valid", {63'd0, disp_i_valid}, 64'd0);

    // Asynchronous reset in the middle of a flush.
    step();
    redir_req = 1'b1; redir_op1 = 32'h400; redir_op2 = 32'h8;
    step();
    redir_req = 1'b0;
    @(negedge clk);
    check("rstflush_req_up", {63'd0, pipe_flush_req}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstflush_req_drop", {63'd0, pipe_flush_req}, 64'd0);
    check("rstflush_active", {63'd0, exu_rx_active}, 64'd0);
    check("rstflush_op1", {32'd0, pipe_flush_add_op1}, 64'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("rstflush_ifu_ready", {63'd0, ifu_o_ready}, 64'd1);
    check("rstflush_disp_valid", {63'd0, disp_i_valid}, 64'd0);

    repeat (2) step();
    check("final_drain", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
